// File: rtl/ext_pipe.sv
// Immediate / load-data extension unit with a registered valid-ready output stage.
// Latency 1 cycle; a 2-entry output/skid pair keeps full throughput, and in_ready is a pure register.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHAMT  = 2,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err
);

  logic [DATA_W-1:0] imm_sx;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] new_res;
  logic              new_err;

  logic              or_vld_q, or_vld_d;
  logic [DATA_W-1:0] or_res_q, or_res_d;
  logic              or_err_q, or_err_d;
  logic              sr_vld_q, sr_vld_d;
  logic [DATA_W-1:0] sr_res_q, sr_res_d;
  logic              sr_err_q, sr_err_d;

  logic accept;
  logic drain;

  always_comb begin
    imm_sx   = DATA_W'($signed(in_imm));
    byte_sel = in_data[8*in_off +: 8];
    half_sel = in_data[16*(in_off >> 1) +: 16];
    new_res  = '0;
    new_err  = 1'b0;
    case (in_op)
      3'b000: new_res = imm_sx;
      3'b001: new_res = DATA_W'(in_imm);
      3'b010: new_res = DATA_W'(in_imm) << (DATA_W - IMM_W);
      3'b011: new_res = imm_sx << SHAMT;
      3'b100: new_res = DATA_W'($signed(byte_sel));
      3'b101: new_res = DATA_W'(byte_sel);
      default: begin
        // Odd offset on a halfword access: flag it and force a zero result.
        if (in_off[0]) begin
          new_err = 1'b1;
        end else if (in_op[0]) begin
          new_res = DATA_W'(half_sel);
        end else begin
          new_res = DATA_W'($signed(half_sel));
        end
      end
    endcase
  end

  assign accept = in_valid && in_ready;
  assign drain  = or_vld_q && out_ready;

  always_comb begin
    or_vld_d = or_vld_q;
    or_res_d = or_res_q;
    or_err_d = or_err_q;
    sr_vld_d = sr_vld_q;
    sr_res_d = sr_res_q;
    sr_err_d = sr_err_q;

    if (!or_vld_q || drain) begin
      if (sr_vld_q) begin
        or_vld_d = 1'b1;
        or_res_d = sr_res_q;
        or_err_d = sr_err_q;
        sr_vld_d = 1'b0;
      end else if (accept) begin
        or_vld_d = 1'b1;
        or_res_d = new_res;
        or_err_d = new_err;
      end else begin
        or_vld_d = 1'b0;
      end
    end else if (accept) begin
      // Output is stalled: park the new entry in the skid register.
      sr_vld_d = 1'b1;
      sr_res_d = new_res;
      sr_err_d = new_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_vld_q <= 1'b0;
      or_res_q <= '0;
      or_err_q <= 1'b0;
      sr_vld_q <= 1'b0;
      sr_res_q <= '0;
      sr_err_q <= 1'b0;
    end else begin
      or_vld_q <= or_vld_d;
      or_res_q <= or_res_d;
      or_err_q <= or_err_d;
      sr_vld_q <= sr_vld_d;
      sr_res_q <= sr_res_d;
      sr_err_q <= sr_err_d;
    end
  end

  assign in_ready   = !sr_vld_q;
  assign out_valid  = or_vld_q;
  assign out_result = or_res_q;
  assign out_err    = or_err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: extension modes, error flag, backpressure, streaming and async reset.
module tb_ext_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;

  int n_checks;
  int n_fail;

  ext_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .in_data   (in_data),
    .in_off    (in_off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Drive one request from an empty pipe; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] imm,
                       input logic [31:0] data, input logic [1:0] off);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    in_data  = data;
    in_off   = off;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_imm = '0; in_data = '0; in_off = '0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%b err=%b res=%h rdy=%b required 0 0 00000000 1",
               out_valid, out_err, out_result, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_imm();
    logic [2:0]  ops[4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] exp[4] = '{32'hFFFF8900, 32'h00008900, 32'h89000000, 32'hFFFE2400};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 16'h8900, 32'hDEADBEEF, 2'd3);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== exp[i] || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL imm_op%0d: got vld=%b res=%h err=%b required 1 %h 0",
                 i, out_valid, out_result, out_err, exp[i]);
      end
    end
  endtask

  task automatic test_byte();
    logic [2:0]  ops[3]  = '{3'b100, 3'b101, 3'b100};
    logic [1:0]  offs[3] = '{2'd1, 2'd1, 2'd0};
    logic [31:0] exp[3]  = '{32'hFFFFFF86, 32'h00000086, 32'h00000078};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 16'hFFFF, 32'h12348678, offs[i]);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== exp[i] || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL byte_%0d: got vld=%b res=%h err=%b required 1 %h 0",
                 i, out_valid, out_result, out_err, exp[i]);
      end
    end
  endtask

  task automatic test_half();
    logic [2:0]  ops[6]  = '{3'b110, 3'b111, 3'b110, 3'b110, 3'b111, 3'b111};
    logic [1:0]  offs[6] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] exp[6]  = '{32'hFFFF8678, 32'h00008678, 32'h00001234,
                             32'h0, 32'h0, 32'h00001234};
    logic        errs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], 16'h0, 32'h12348678, offs[i]);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== exp[i] || out_err !== errs[i]) begin
        n_fail++;
        $display("FAIL half_%0d: got vld=%b res=%h err=%b required 1 %h %b",
                 i, out_valid, out_result, out_err, exp[i], errs[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    int last_cyc = -1;
    logic acc;
    logic xfer;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'b001;
    in_imm    = 16'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      #1;
      in_imm = 16'(idx + 1);
    end
    @(negedge clk);
    n_checks++;
    if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd1) begin
      n_fail++;
      $display("FAIL bp_stall: got accepted=%0d rdy=%b vld=%b res=%h required 2 0 1 00000001",
               idx, in_ready, out_valid, out_result);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        n_checks++;
        if (out_result !== 32'(got + 1) || (last_cyc >= 0 && c != last_cyc + 1)) begin
          n_fail++;
          $display("FAIL bp_drain_%0d: got res=%h cycle=%0d required %h cycle=%0d",
                   got, out_result, c, 32'(got + 1), last_cyc + 1);
        end
        got++;
        last_cyc = c;
      end
      @(posedge clk);
      if (acc) idx++;
      #1;
      if (idx < 4) in_imm = 16'(idx + 1);
      else in_valid = 1'b0;
    end
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results required 4", got);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'b001;
    for (int k = 0; k < 9; k++) begin
      in_imm = 16'(10 + k);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || (k > 0 && (out_valid !== 1'b1 || out_result !== 32'(10 + k - 1)))) begin
        n_fail++;
        $display("FAIL b2b_%0d: got rdy=%b vld=%b res=%h required 1 1 %h",
                 k, in_ready, out_valid, out_result, 32'(10 + k - 1));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd18) begin
      n_fail++;
      $display("FAIL b2b_last: got vld=%b res=%h required 1 00000012", out_valid, out_result);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'b111;
    in_off    = 2'd1;
    in_data   = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_fill: got vld=%b err=%b rdy=%b required 1 1 0",
               out_valid, out_err, in_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_async: got vld=%b err=%b res=%h rdy=%b required 0 0 00000000 1",
               out_valid, out_err, out_result, in_ready);
    end
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    issue(3'b001, 16'h0077, 32'h0, 2'd0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h77 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_new: got vld=%b res=%h err=%b required 1 00000077 0",
               out_valid, out_result, out_err);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: got vld=%b res=%h required vld 0", out_valid, out_result);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_imm();
    test_byte();
    test_half();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
